resilient_issue_governor: RTL and testbench
===========================================

Name: resilient_issue_governor

Overview:
- Synchronous token-issue controller for an error-detecting bundled-data pipeline stage.
- Launches tokens into the stage's left channel with a 2-phase lreq toggle and waits for the 2-phase lack.
- Accumulates the stage's per-token timing-error reports (Err0 = short recovery, Err1 = long recovery) over fixed windows of completed transfers.
- Adapts the inter-issue gap at each window end: errors above threshold slow issue, error-free windows speed it up.

Parameters:
SYNC_STAGES, 2, flops in lack synchronizer (min 2)
GAP_W, 4, width of gap level; GAP_MAX = 2^GAP_W-1
GAP_INIT, 2, gap level after reset
WIN_LOG2, 4, window = 2^WIN_LOG2 completed transfers
UP_THRESH, 3, weighted window error count that raises gap
CNT_W, 16, width of total error counters
TIMEOUT_CYCLES, 255, ack watchdog limit (optional feature only)

Ports:
clk  in  1  clock, rising edge
rst  in  1  synchronous, active-high reset
in_valid  in  1  source has a token to issue
in_ready  out  1  one-cycle pulse: token accepted/issued this cycle
lreq  out  1  2-phase request to stage (toggles per token)
lack  in  1  2-phase ack from stage, asynchronous, synchronized internally
err_valid  in  1  one-cycle strobe: err_code valid (clk domain)
err_code  in  2  00 none, 01 Err0, 10 Err1, 11 treated as Err1
gap_level  out  GAP_W  current inter-issue gap (cycles)
busy  out  1  token outstanding (lreq != synchronized lack)
err0_total  out  CNT_W  saturating count of Err0 reports
err1_total  out  CNT_W  saturating count of Err1 reports
timeout  out  1  sticky watchdog flag (0 when feature disabled)

Behaviour:
Reset (rst=1 at edge):
- lreq=0, sync chain=0, in_ready=0, busy=0, gap_level=GAP_INIT, totals=0, window counters=0, timeout=0, state=IDLE.
- Reset mid-transfer abandons the token. The stage is reset in the same cycle by system convention.

FSM:
- IDLE: if in_valid and gap_cnt==0, toggle lreq, pulse in_ready, go WAIT_ACK.
- WAIT_ACK: when lack_s==lreq, the transfer is complete. Increment xfer_cnt, load gap_cnt=gap_level, go GAP (or IDLE if gap_level==0).
- GAP: decrement gap_cnt each cycle; at 0 go IDLE.
- Minimum issue-to-issue time = SYNC_STAGES + 1 + gap_level cycles past ack arrival. in_ready never pulses while busy.

Error accounting:
- err_valid with 01: win_err += 1, err0_total += 1.
- err_valid with 10/11: win_err += 2, err1_total += 1.
- 00 is ignored.
- win_err is (WIN_LOG2+2) bits and saturates. Totals saturate at all-ones.
- err_valid is accepted in any state, including IDLE.

Window end (xfer_cnt wraps from 2^WIN_LOG2-1 to 0 on a completion):
- If win_err (including any err_valid in the same cycle) >= UP_THRESH: gap_level = min(gap_level+1, GAP_MAX).
- Else if win_err==0: gap_level = max(gap_level-1, 0).
- Else: gap_level is unchanged.
- win_err clears to 0 the following cycle. An err_valid in the window-end cycle counts toward the closing window, not the new one.
- The new gap_level takes effect for the gap following this completion.

Optional Feature:
- Macro: RIG_ACK_TIMEOUT_EN.
- Defined: a watchdog counts cycles in WAIT_ACK. If TIMEOUT_CYCLES elapse without completion, set timeout=1 and enter HALT. HALT issues nothing (in_ready=0), holds counters, and exits only on rst.
- Undefined: no watchdog; WAIT_ACK waits indefinitely; timeout tied to 0.

Test Plan:
- Reset, in_valid=1, stage echoes lreq to lack after 3 cycles, GAP_INIT=2 -> in_ready pulse at cycle 1, lreq 0->1; next pulse exactly 3+2+2+1 cycles later; busy high only while outstanding.
- 16 transfers, no errors, gap_level=2 -> after 16th completion gap_level=1; after next 16 -> 0; after further 16 stays 0 (floor).
- Window with two Err1 reports (win_err=4 >= 3) -> gap_level 2->3; err1_total=2. With GAP_MAX reached, stays 15.
- err_valid=01 in same cycle as 16th completion, win_err previously 2 -> closing window sees 3, gap_level increments; next window starts at 0.
- err_code=11 five times, 01 three times -> err1_total=5, err0_total=3. Preload near saturation and confirm counters hold at 0xFFFF.
- With RIG_ACK_TIMEOUT_EN, lack stuck -> timeout=1 after 255 WAIT_ACK cycles, no further in_ready; rst clears all. Without the macro, same stimulus -> timeout stays 0, busy stays 1.

Source files
------------

// File: rtl/resilient_issue_governor.sv
// Token-issue governor for an error-detecting bundled-data stage: 2-phase lreq/lack
// handshake with a window-adaptive inter-issue gap. Define RIG_ACK_TIMEOUT_EN for the ack watchdog.
module resilient_issue_governor #(
    parameter int SYNC_STAGES    = 2,
    parameter int GAP_W          = 4,
    parameter int GAP_INIT       = 2,
    parameter int WIN_LOG2       = 4,
    parameter int UP_THRESH      = 3,
    parameter int CNT_W          = 16,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    output logic             lreq,
    input  logic             lack,
    input  logic             err_valid,
    input  logic [1:0]       err_code,
    output logic [GAP_W-1:0] gap_level,
    output logic             busy,
    output logic [CNT_W-1:0] err0_total,
    output logic [CNT_W-1:0] err1_total,
    output logic             timeout
);

    localparam logic [1:0] IDLE     = 2'd0;
    localparam logic [1:0] WAIT_ACK = 2'd1;
    localparam logic [1:0] GAP      = 2'd2;
    localparam logic [1:0] HALT     = 2'd3;
    localparam int         WE_W     = WIN_LOG2 + 2;

    logic [1:0]             state;
    logic [SYNC_STAGES-1:0] lack_sync;
    logic                   lack_s;
    logic [GAP_W-1:0]       gap_cnt;
    logic [GAP_W-1:0]       gap_next;
    logic [WIN_LOG2-1:0]    xfer_cnt;
    logic [WE_W-1:0]        win_err;
    logic [WE_W-1:0]        win_err_next;
    logic [WE_W:0]          win_sum;
    logic [1:0]             err_inc;
    logic                   issue;
    logic                   complete;
    logic                   window_end;
    logic                   wd_expire;

    assign lack_s     = lack_sync[SYNC_STAGES-1];
    assign busy       = lreq ^ lack_s;
    assign issue      = !rst && (state == IDLE) && in_valid && (gap_cnt == '0) && !busy;
    assign in_ready   = issue;
    assign complete   = (state == WAIT_ACK) && !busy;
    assign window_end = complete && (xfer_cnt == '1);

    always_ff @(posedge clk) begin
        if (rst) begin
            lack_sync <= '0;
        end else begin
            lack_sync <= {lack_sync[SYNC_STAGES-2:0], lack};
        end
    end

    // Err1 weighs double in the window score; the closing window sees a same-cycle report.
    always_comb begin
        err_inc = 2'd0;
        if (err_valid) begin
            case (err_code)
                2'b01:        err_inc = 2'd1;
                2'b10, 2'b11: err_inc = 2'd2;
                default:      err_inc = 2'd0;
            endcase
        end
        win_sum      = {1'b0, win_err} + {{(WE_W-1){1'b0}}, err_inc};
        win_err_next = win_sum[WE_W] ? '1 : win_sum[WE_W-1:0];
        gap_next     = gap_level;
        if (window_end) begin
            if (win_err_next >= WE_W'(UP_THRESH)) begin
                if (gap_level != '1) gap_next = gap_level + GAP_W'(1);
            end else if (win_err_next == '0) begin
                if (gap_level != '0) gap_next = gap_level - GAP_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            lreq       <= 1'b0;
            gap_cnt    <= '0;
            gap_level  <= GAP_W'(GAP_INIT);
            xfer_cnt   <= '0;
            win_err    <= '0;
            err0_total <= '0;
            err1_total <= '0;
        end else begin
            if (err_valid && (err_code == 2'b01) && (err0_total != '1))
                err0_total <= err0_total + CNT_W'(1);
            if (err_valid && err_code[1] && (err1_total != '1))
                err1_total <= err1_total + CNT_W'(1);
            win_err <= window_end ? '0 : win_err_next;

            case (state)
                IDLE: begin
                    if (issue) begin
                        lreq  <= ~lreq;
                        state <= WAIT_ACK;
                    end
                end
                WAIT_ACK: begin
                    if (complete) begin
                        xfer_cnt  <= xfer_cnt + WIN_LOG2'(1);
                        gap_level <= gap_next;
                        gap_cnt   <= gap_next;
                        state     <= (gap_next == '0) ? IDLE : GAP;
                    end else if (wd_expire) begin
                        state <= HALT;
                    end
                end
                GAP: begin
                    gap_cnt <= gap_cnt - GAP_W'(1);
                    if (gap_cnt <= GAP_W'(1)) state <= IDLE;
                end
                HALT: begin
                    state <= HALT;
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef RIG_ACK_TIMEOUT_EN
    localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [WD_W-1:0] wd_cnt;
    logic            timeout_q;

    // Expires on the last permitted WAIT_ACK cycle; HALT is only left through rst.
    assign wd_expire = (state == WAIT_ACK) && !complete && (wd_cnt == WD_W'(TIMEOUT_CYCLES - 1));
    assign timeout   = timeout_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            wd_cnt    <= '0;
            timeout_q <= 1'b0;
        end else begin
            if ((state == WAIT_ACK) && !complete) wd_cnt <= wd_cnt + WD_W'(1);
            else                                  wd_cnt <= '0;
            if (wd_expire) timeout_q <= 1'b1;
        end
    end
`else
    assign wd_expire = 1'b0;
    assign timeout   = 1'b0;
`endif

endmodule

// File: tb/tb_resilient_issue_governor.sv
// Scoreboard bench for resilient_issue_governor: expected issue attributes are queued by the
// stimulus and popped by a monitor on every in_ready pulse; directed checks cover reset/totals.
module tb_resilient_issue_governor;

    localparam int PULSE_LIMIT = 100;

    typedef struct {
        logic       lreq_pre;
        logic [3:0] gap;
        int         interval;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid;
    logic       in_ready;
    logic       lreq;
    logic       lack;
    logic       err_valid;
    logic [1:0] err_code;
    logic [3:0] gap_level;
    logic       busy;
    logic [15:0] err0_total;
    logic [15:0] err1_total;
    logic       timeout;

    logic       sat_err_valid;
    logic [1:0] sat_err_code;
    logic       sat_in_ready;
    logic       sat_lreq;
    logic [3:0] sat_gap;
    logic       sat_busy;
    logic [3:0] sat_err0;
    logic [3:0] sat_err1;
    logic       sat_timeout;

    logic       echo_en;
    exp_t       exp_q[$];
    exp_t       mon_e;
    int         total = 0;
    int         bad = 0;
    int         cycle_cnt = 0;
    int         last_pulse = 0;
    int         gap_m, xfer_m, win_m, err0_m, err1_m, issues_m;

    resilient_issue_governor dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .lreq(lreq), .lack(lack), .err_valid(err_valid), .err_code(err_code),
        .gap_level(gap_level), .busy(busy), .err0_total(err0_total),
        .err1_total(err1_total), .timeout(timeout)
    );

    resilient_issue_governor #(.CNT_W(4)) dut_sat (
        .clk(clk), .rst(rst), .in_valid(1'b0), .in_ready(sat_in_ready),
        .lreq(sat_lreq), .lack(1'b0), .err_valid(sat_err_valid), .err_code(sat_err_code),
        .gap_level(sat_gap), .busy(sat_busy), .err0_total(sat_err0),
        .err1_total(sat_err1), .timeout(sat_timeout)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cycle_cnt++;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("[TB] FAIL %s: got %0d expected %0d", name, actual, expected);
        end
    endtask

    task automatic finish_up();
        checkOutput("queue_drained", 32'(exp_q.size()), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    endtask

    // Stage model: returns lack to match lreq three clock edges after lreq toggles.
    always begin
        @(posedge clk);
        #1;
        if (echo_en && !rst && (lack != lreq)) begin
            @(posedge clk);
            @(posedge clk);
            @(negedge clk);
            if (echo_en && !rst) lack = lreq;
        end
    end

    always @(negedge clk) begin
        if (!rst && in_ready) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("[TB] FAIL unexpected_in_ready: pulse at cycle %0d with nothing expected", cycle_cnt);
            end else begin
                mon_e = exp_q.pop_front();
                checkOutput("issue_lreq", 32'(lreq), 32'(mon_e.lreq_pre));
                checkOutput("issue_gap", 32'(gap_level), 32'(mon_e.gap));
                checkOutput("issue_busy", 32'(busy), 0);
                if (mon_e.interval > 0)
                    checkOutput("issue_interval", 32'(cycle_cnt - last_pulse), 32'(mon_e.interval));
            end
            last_pulse = cycle_cnt;
        end
    end

    task automatic push_expect(input int interval);
        exp_t e;
        e.lreq_pre = issues_m[0];
        e.gap      = gap_m[3:0];
        e.interval = interval;
        exp_q.push_back(e);
        issues_m++;
    endtask

    task automatic model_err(input logic [1:0] code);
        if (code == 2'b01) begin
            win_m = (win_m + 1 > 63) ? 63 : win_m + 1;
            err0_m++;
        end else if (code[1]) begin
            win_m = (win_m + 2 > 63) ? 63 : win_m + 2;
            err1_m++;
        end
    endtask

    task automatic model_complete();
        xfer_m++;
        if (xfer_m == 16) begin
            xfer_m = 0;
            if (win_m >= 3) gap_m = (gap_m == 15) ? 15 : gap_m + 1;
            else if (win_m == 0) gap_m = (gap_m == 0) ? 0 : gap_m - 1;
            win_m = 0;
        end
    endtask

    task automatic model_reset();
        gap_m = 2; xfer_m = 0; win_m = 0; err0_m = 0; err1_m = 0; issues_m = 0;
    endtask

    task automatic drive_raw(input logic valid, input logic [1:0] code);
        err_valid = valid;
        err_code  = code;
        @(posedge clk);
        #1;
        err_valid = 1'b0;
        err_code  = 2'b00;
    endtask

    task automatic drive_sat(input logic [1:0] code);
        sat_err_valid = 1'b1;
        sat_err_code  = code;
        @(posedge clk);
        #1;
        sat_err_valid = 1'b0;
        sat_err_code  = 2'b00;
    endtask

    task automatic wait_pulse(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < PULSE_LIMIT; i++) begin
            @(negedge clk);
            if (in_ready) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    // One transfer: early error lands mid-flight, late error lands in the completion cycle.
    task automatic applyStimulus(input logic [1:0] early, input logic [1:0] late, input bit last);
        bit ok;
        wait_pulse(ok);
        if (!ok) begin
            total++;
            bad++;
            $display("[TB] FAIL issue_wait: no in_ready within %0d cycles", PULSE_LIMIT);
            finish_up();
        end
        @(posedge clk);
        #1;
        if (last) in_valid = 1'b0;
        checkOutput("busy_after_issue", 32'(busy), 1);
        @(posedge clk);
        #1;
        drive_raw(early != 2'b00, early);
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        drive_raw(late != 2'b00, late);
        checkOutput("busy_after_done", 32'(busy), 0);
        model_err(early);
        model_err(late);
        model_complete();
        if (!last) push_expect(6 + gap_m);
    endtask

    initial begin
        logic [1:0] early;
        logic [1:0] late;
        bit         ok;
        rst = 1'b1; in_valid = 1'b0; lack = 1'b0; err_valid = 1'b0; err_code = 2'b00;
        sat_err_valid = 1'b0; sat_err_code = 2'b00; echo_en = 1'b1;
        model_reset();
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        $display("[TB] reset state");
        checkOutput("rst_lreq", 32'(lreq), 0);
        checkOutput("rst_in_ready", 32'(in_ready), 0);
        checkOutput("rst_busy", 32'(busy), 0);
        checkOutput("rst_gap", 32'(gap_level), 2);
        checkOutput("rst_err0", 32'(err0_total), 0);
        checkOutput("rst_err1", 32'(err1_total), 0);
        checkOutput("rst_timeout", 32'(timeout), 0);
        checkOutput("rst_sat_idle", 32'({sat_in_ready, sat_lreq, sat_busy, sat_timeout}), 0);
        checkOutput("rst_sat_gap", 32'(sat_gap), 2);

        $display("[TB] adaptive windows");
        push_expect(0);
        @(posedge clk);
        #1 in_valid = 1'b1;
        for (int w = 0; w < 22; w++) begin
            for (int t = 0; t < 16; t++) begin
                early = 2'b00;
                late  = 2'b00;
                case (w)
                    3: if (t == 0 || t == 5) early = 2'b10;
                    4: begin
                        if (t == 3)  early = 2'b10;
                        if (t == 15) late  = 2'b01;
                    end
                    6: if (t == 7) early = 2'b01;
                    default: if (w >= 7 && t < 2) early = 2'b11;
                endcase
                applyStimulus(early, late, (w == 21) && (t == 15));
            end
            if (w == 1) checkOutput("gap_after_two_clean", 32'(gap_level), 0);
            if (w == 4) checkOutput("gap_after_late_err0", 32'(gap_level), 2);
        end
        checkOutput("gap_clamped_max", 32'(gap_level), 15);
        checkOutput("err0_after_windows", 32'(err0_total), 2);
        checkOutput("err1_after_windows", 32'(err1_total), 33);

        $display("[TB] idle error reports");
        repeat (20) @(posedge clk);
        #1;
        for (int i = 0; i < 5; i++) drive_raw(1'b1, 2'b11);
        for (int i = 0; i < 3; i++) drive_raw(1'b1, 2'b01);
        for (int i = 0; i < 2; i++) drive_raw(1'b1, 2'b00);
        @(negedge clk);
        checkOutput("err1_idle", 32'(err1_total), 38);
        checkOutput("err0_idle", 32'(err0_total), 5);
        checkOutput("gap_idle_hold", 32'(gap_level), 15);

        $display("[TB] total saturation");
        @(posedge clk);
        #1;
        for (int i = 0; i < 14; i++) drive_sat(2'b01);
        checkOutput("sat_err0_below", 32'(sat_err0), 14);
        for (int i = 0; i < 6; i++) drive_sat(2'b01);
        checkOutput("sat_err0_hold", 32'(sat_err0), 15);
        for (int i = 0; i < 18; i++) drive_sat(2'b10);
        checkOutput("sat_err1_hold", 32'(sat_err1), 15);
        checkOutput("sat_err0_still", 32'(sat_err0), 15);

        $display("[TB] stuck ack");
        echo_en = 1'b0;
        push_expect(0);
        in_valid = 1'b1;
        wait_pulse(ok);
        checkOutput("stuck_issue_seen", 32'(ok), 1);
        repeat (300) @(posedge clk);
        @(negedge clk);
        checkOutput("stuck_busy", 32'(busy), 1);
`ifdef RIG_ACK_TIMEOUT_EN
        checkOutput("stuck_timeout", 32'(timeout), 1);
`else
        checkOutput("stuck_timeout", 32'(timeout), 0);
`endif
        @(posedge clk);
        #1;
        rst = 1'b1; lack = 1'b0; in_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        model_reset();
        @(negedge clk);
        checkOutput("rerst_lreq", 32'(lreq), 0);
        checkOutput("rerst_busy", 32'(busy), 0);
        checkOutput("rerst_gap", 32'(gap_level), 2);
        checkOutput("rerst_err0", 32'(err0_total), 0);
        checkOutput("rerst_err1", 32'(err1_total), 0);
        checkOutput("rerst_timeout", 32'(timeout), 0);

        echo_en = 1'b1;
        push_expect(0);
        @(posedge clk);
        #1 in_valid = 1'b1;
        applyStimulus(2'b00, 2'b00, 1'b1);
        repeat (4) @(posedge clk);
        @(negedge clk);
        checkOutput("post_rst_gap", 32'(gap_level), 2);
        checkOutput("post_rst_lreq", 32'(lreq), 1);
        finish_up();
    end

endmodule
